// File: rtl/dct_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dct_pkg
// Purpose  : DCT cosine constants, accumulator sizing and round/saturate helper
// Revision : 1.0 - initial release
// ============================================================================
package dct_pkg;

    localparam int C1 = 126;
    localparam int C2 = 118;
    localparam int C3 = 106;
    localparam int C4 = 91;
    localparam int C5 = 71;
    localparam int C6 = 49;
    localparam int C7 = 25;

    // Working width of the round/saturate helper; callers narrow the result
    localparam int SR_W = 48;

    typedef struct packed {
        logic                   sat;
        logic signed [SR_W-1:0] val;
    } sat_res_t;

    function automatic int acc_w(input int in_w);
        return in_w + 11;
    endfunction

    function automatic sat_res_t sat_round(input logic signed [SR_W-1:0] value,
                                           input int shift,
                                           input int out_w);
        logic signed [SR_W-1:0] r;
        logic signed [SR_W-1:0] hi;
        logic signed [SR_W-1:0] lo;
        sat_res_t               res;
        if (shift > 0)
            r = (value + (SR_W'(1) <<< (shift - 1))) >>> shift;
        else
            r = value;
        hi = (SR_W'(1) <<< (out_w - 1)) - SR_W'(1);
        lo = -(SR_W'(1) <<< (out_w - 1));
        res.sat = 1'b0;
        res.val = r;
        if (r > hi) begin
            res.sat = 1'b1;
            res.val = hi;
        end else if (r < lo) begin
            res.sat = 1'b1;
            res.val = lo;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dct8_odd.sv
`default_nettype none
// ============================================================================
// Module   : dct8_odd
// Purpose  : Odd-part 4x4 constant multiply/accumulate (d0..d3 -> X1,X3,X5,X7)
// Revision : 1.0 - initial release
// ============================================================================
module dct8_odd
    import dct_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int ACC_W = acc_w(IN_W)
) (
    input  logic signed [IN_W:0]    i_d0,
    input  logic signed [IN_W:0]    i_d1,
    input  logic signed [IN_W:0]    i_d2,
    input  logic signed [IN_W:0]    i_d3,
    output logic signed [ACC_W-1:0] o_x1,
    output logic signed [ACC_W-1:0] o_x3,
    output logic signed [ACC_W-1:0] o_x5,
    output logic signed [ACC_W-1:0] o_x7
);

    localparam logic signed [ACC_W-1:0] K1 = ACC_W'(C1);
    localparam logic signed [ACC_W-1:0] K3 = ACC_W'(C3);
    localparam logic signed [ACC_W-1:0] K5 = ACC_W'(C5);
    localparam logic signed [ACC_W-1:0] K7 = ACC_W'(C7);

    logic signed [ACC_W-1:0] w_e0;
    logic signed [ACC_W-1:0] w_e1;
    logic signed [ACC_W-1:0] w_e2;
    logic signed [ACC_W-1:0] w_e3;

    assign w_e0 = ACC_W'(i_d0);
    assign w_e1 = ACC_W'(i_d1);
    assign w_e2 = ACC_W'(i_d2);
    assign w_e3 = ACC_W'(i_d3);

    assign o_x1 = K1 * w_e0 + K3 * w_e1 + K5 * w_e2 + K7 * w_e3;
    assign o_x3 = K3 * w_e0 - K7 * w_e1 - K1 * w_e2 - K5 * w_e3;
    assign o_x5 = K5 * w_e0 - K1 * w_e1 + K7 * w_e2 + K3 * w_e3;
    assign o_x7 = K7 * w_e0 - K5 * w_e1 + K3 * w_e2 - K1 * w_e3;

endmodule
`default_nettype wire

// File: rtl/dct8_pipe.sv
`default_nettype none
// ============================================================================
// Module   : dct8_pipe
// Purpose  : 3-stage pipelined 8-point forward DCT with round/saturate and row tag
// Revision : 1.0 - initial release
// ============================================================================
module dct8_pipe
    import dct_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 12,
    parameter int SHIFT = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*IN_W-1:0]    in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*OUT_W-1:0]   out_data,
    output logic [7:0]           out_sat,
    output logic [2:0]           out_row,
    output logic                 out_last
);

    localparam int ACC_W = acc_w(IN_W);
    localparam logic signed [ACC_W-1:0] K2 = ACC_W'(C2);
    localparam logic signed [ACC_W-1:0] K4 = ACC_W'(C4);
    localparam logic signed [ACC_W-1:0] K6 = ACC_W'(C6);

    logic w_en;
    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    logic [2:0] r_row;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                r_row <= 3'd0;
        else if (in_valid && w_en) r_row <= r_row + 3'd1;
    end

    // Stage 1: butterflies
    logic signed [IN_W-1:0] w_p [8];
    logic signed [IN_W:0]   w_s [4];
    logic signed [IN_W:0]   w_d [4];
    generate
        for (genvar k = 0; k < 8; k++) begin : g_unpack
            assign w_p[k] = in_data[(8-k)*IN_W-1 -: IN_W];
        end
        for (genvar k = 0; k < 4; k++) begin : g_bfly
            assign w_s[k] = (IN_W+1)'(w_p[k]) + (IN_W+1)'(w_p[7-k]);
            assign w_d[k] = (IN_W+1)'(w_p[k]) - (IN_W+1)'(w_p[7-k]);
        end
    endgenerate

    logic signed [IN_W+1:0] w_b1, w_b2, w_b3, w_b4;
    assign w_b1 = (IN_W+2)'(w_s[0]) + (IN_W+2)'(w_s[3]);
    assign w_b2 = (IN_W+2)'(w_s[1]) + (IN_W+2)'(w_s[2]);
    assign w_b3 = (IN_W+2)'(w_s[0]) - (IN_W+2)'(w_s[3]);
    assign w_b4 = (IN_W+2)'(w_s[1]) - (IN_W+2)'(w_s[2]);

    logic                   r_v1;
    logic [2:0]             r_row1;
    logic signed [IN_W+1:0] r_b1, r_b2, r_b3, r_b4;
    logic signed [IN_W:0]   r_d [4];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_row1 <= 3'd0;
            r_b1   <= '0;
            r_b2   <= '0;
            r_b3   <= '0;
            r_b4   <= '0;
            for (int k = 0; k < 4; k++) r_d[k] <= '0;
        end else if (w_en) begin
            r_v1   <= in_valid;
            r_row1 <= r_row;
            r_b1   <= w_b1;
            r_b2   <= w_b2;
            r_b3   <= w_b3;
            r_b4   <= w_b4;
            for (int k = 0; k < 4; k++) r_d[k] <= w_d[k];
        end
    end

    // Stage 2: even part inline, odd part in the sub-module
    logic signed [ACC_W-1:0] w_eb1, w_eb2, w_eb3, w_eb4;
    logic signed [ACC_W-1:0] w_x [8];
    assign w_eb1 = ACC_W'(r_b1);
    assign w_eb2 = ACC_W'(r_b2);
    assign w_eb3 = ACC_W'(r_b3);
    assign w_eb4 = ACC_W'(r_b4);

    assign w_x[0] = K4 * (w_eb1 + w_eb2);
    assign w_x[4] = K4 * (w_eb1 - w_eb2);
    assign w_x[2] = K2 * w_eb3 + K6 * w_eb4;
    assign w_x[6] = K6 * w_eb3 - K2 * w_eb4;

    dct8_odd #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_odd (
        .i_d0 (r_d[0]),
        .i_d1 (r_d[1]),
        .i_d2 (r_d[2]),
        .i_d3 (r_d[3]),
        .o_x1 (w_x[1]),
        .o_x3 (w_x[3]),
        .o_x5 (w_x[5]),
        .o_x7 (w_x[7])
    );

    logic                    r_v2;
    logic [2:0]              r_row2;
    logic signed [ACC_W-1:0] r_x [8];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2   <= 1'b0;
            r_row2 <= 3'd0;
            for (int k = 0; k < 8; k++) r_x[k] <= '0;
        end else if (w_en) begin
            r_v2   <= r_v1;
            r_row2 <= r_row1;
            for (int k = 0; k < 8; k++) r_x[k] <= w_x[k];
        end
    end

    // Stage 3: round, saturate, pack X0 into the MSBs
    logic [8*OUT_W-1:0] w_data;
    logic [7:0]         w_sat;
    generate
        for (genvar k = 0; k < 8; k++) begin : g_round
            sat_res_t               w_res;
            logic [SR_W-OUT_W-1:0]  w_unused_hi;
            assign w_res       = sat_round(SR_W'(r_x[k]), SHIFT, OUT_W);
            assign w_data[(8-k)*OUT_W-1 -: OUT_W] = w_res.val[OUT_W-1:0];
            assign w_sat[7-k]  = w_res.sat;
            assign w_unused_hi = w_res.val[SR_W-1:OUT_W];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 8'd0;
            out_row   <= 3'd0;
            out_last  <= 1'b0;
        end else if (w_en) begin
            out_valid <= r_v2;
            out_data  <= w_data;
            out_sat   <= w_sat;
            out_row   <= r_row2;
            out_last  <= (r_row2 == 3'd7);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dct8_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_dct8_pipe
// Purpose  : Scoreboard bench for dct8_pipe (directed, random stall, reset cases)
// Revision : 1.0 - initial release
// ============================================================================
module tb_dct8_pipe;

    localparam int IN_W  = 8;
    localparam int OUT_W = 12;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [8*IN_W-1:0]   in_data = '0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [8*OUT_W-1:0]  out_data;
    logic [7:0]          out_sat;
    logic [2:0]          out_row;
    logic                out_last;

    always #5 clk = ~clk;

    dct8_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_row   (out_row),
        .out_last  (out_last)
    );

    typedef struct packed {
        logic [95:0] data;
        logic [7:0]  sat;
        logic [2:0]  row;
        logic        last;
        logic [31:0] cyc;
        logic        lat;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] cyc      = 0;
    logic [2:0]  row_exp  = 0;
    logic        lat_mode = 1'b0;
    logic        stall_prev = 1'b0;
    logic [95:0] held_data;
    logic [7:0]  held_sat;
    logic [2:0]  held_row;
    logic        held_last;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [63:0] d, input logic [2:0] row);
        int   p [8];
        int   x [8];
        int   r;
        exp_t e;
        for (int k = 0; k < 8; k++) p[k] = $signed(d[(7-k)*8 +: 8]);
        x[0] = 91 * (p[0] + p[1] + p[2] + p[3] + p[4] + p[5] + p[6] + p[7]);
        x[4] = 91 * (p[0] - p[1] - p[2] + p[3] + p[4] - p[5] - p[6] + p[7]);
        x[2] = 118 * (p[0] + p[7] - p[3] - p[4]) + 49 * (p[1] + p[6] - p[2] - p[5]);
        x[6] = 49 * (p[0] + p[7] - p[3] - p[4]) - 118 * (p[1] + p[6] - p[2] - p[5]);
        x[1] = 126 * (p[0] - p[7]) + 106 * (p[1] - p[6]) + 71 * (p[2] - p[5]) + 25 * (p[3] - p[4]);
        x[3] = 106 * (p[0] - p[7]) - 25 * (p[1] - p[6]) - 126 * (p[2] - p[5]) - 71 * (p[3] - p[4]);
        x[5] = 71 * (p[0] - p[7]) - 126 * (p[1] - p[6]) + 25 * (p[2] - p[5]) + 106 * (p[3] - p[4]);
        x[7] = 25 * (p[0] - p[7]) - 71 * (p[1] - p[6]) + 106 * (p[2] - p[5]) - 126 * (p[3] - p[4]);
        e = '0;
        for (int k = 0; k < 8; k++) begin
            r = (x[k] + 4) >>> 3;
            if (r > 2047) begin
                r = 2047;
                e.sat[7-k] = 1'b1;
            end else if (r < -2048) begin
                r = -2048;
                e.sat[7-k] = 1'b1;
            end
            e.data[(7-k)*12 +: 12] = 12'(r);
        end
        e.row  = row;
        e.last = (row == 3'd7);
        e.cyc  = cyc;
        e.lat  = lat_mode;
        return e;
    endfunction

    // One clock cycle, entered and left at the falling edge
    task automatic step(input logic v, input logic [63:0] d, input logic rdy, output logic acc);
        exp_t e;
        in_valid  = v;
        in_data   = d;
        out_ready = rdy;
        #1;
        check("in_ready", 96'(in_ready), 96'(!out_valid || rdy));
        if (stall_prev) begin
            check("hold_valid", 96'(out_valid), 96'(1));
            check("hold_data",  out_data, held_data);
            check("hold_sat",   96'(out_sat), 96'(held_sat));
            check("hold_row",   96'(out_row), 96'(held_row));
            check("hold_last",  96'(out_last), 96'(held_last));
        end
        if (out_valid && rdy) begin
            check("sb_level", 96'(sb.size() > 0), 96'(1));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                for (int k = 0; k < 8; k++)
                    check($sformatf("x%0d", k), 96'(out_data[(7-k)*12 +: 12]), 96'(e.data[(7-k)*12 +: 12]));
                check("sat",  96'(out_sat), 96'(e.sat));
                check("row",  96'(out_row), 96'(e.row));
                check("last", 96'(out_last), 96'(e.last));
                if (e.lat) check("latency", 96'(cyc - e.cyc), 96'(3));
            end
        end
        acc = v && in_ready;
        if (acc) begin
            sb.push_back(model(d, row_exp));
            row_exp = row_exp + 3'd1;
        end
        stall_prev = out_valid && !rdy;
        held_data  = out_data;
        held_sat   = out_sat;
        held_row   = out_row;
        held_last  = out_last;
        @(posedge clk);
        cyc = cyc + 1;
        @(negedge clk);
    endtask

    task automatic send(input logic [63:0] d);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) step(1'b1, d, 1'b1, acc);
        check("send_accepted", 96'(acc), 96'(1));
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 50 && (sb.size() > 0); i++) step(1'b0, 64'd0, 1'b1, acc);
        check("drain_empty", 96'(sb.size()), 96'(0));
    endtask

    initial begin
        logic        acc;
        logic [63:0] d;
        logic        v;
        logic        rdy;
        int          sent;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", 96'(out_valid), 96'(0));
        check("rst_out_data",  out_data, 96'(0));
        check("rst_out_sat",   96'(out_sat), 96'(0));
        check("rst_out_row",   96'(out_row), 96'(0));
        check("rst_out_last",  96'(out_last), 96'(0));
        check("rst_in_ready",  96'(in_ready), 96'(1));
        @(negedge clk);

        // Directed vectors with latency measured on each
        lat_mode = 1'b1;
        send(64'h0000_0000_0000_0000);  drain();
        send(64'h0A0A_0A0A_0A0A_0A0A);  drain();
        send(64'h0A00_0000_0000_00F6);  drain();
        send(64'h7F7F_7F7F_7F7F_7F7F);  drain();
        send(64'h8080_8080_8080_8080);  drain();
        // Back-to-back directed vectors at full rate
        send(64'h0102_0304_0506_0708);
        send(64'hF0E0_D0C0_B0A0_9080);
        send(64'h7F80_7F80_7F80_7F80);
        drain();
        lat_mode = 1'b0;

        // Random stream with random back-pressure
        sent = 0;
        for (int i = 0; i < 400 && sent < 20; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            rdy = $urandom_range(0, 1) == 1;
            d   = {$urandom, $urandom};
            step(v, d, rdy, acc);
            if (acc) sent++;
        end
        check("stream_sent", 96'(sent), 96'(20));
        drain();

        // Reset with two vectors in flight
        step(1'b1, 64'h1111_2222_3333_4444, 1'b1, acc);
        step(1'b1, 64'h5555_6666_7777_0102, 1'b1, acc);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid_rst_valid_async", 96'(out_valid), 96'(0));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("mid_rst_valid", 96'(out_valid), 96'(0));
        check("mid_rst_row",   96'(out_row), 96'(0));
        sb.delete();
        row_exp    = 3'd0;
        stall_prev = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 64'd0, 1'b1, acc);
        send(64'h0A00_0000_0000_00F6);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
